// File: rtl/adc_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : adc_frame_sequencer_if
//  Description : Frame-capture input and per-sample output bundle of the ADC
//                frame sequencer. The master side is the front-end/consumer,
//                and the slave side is the sequencer itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface adc_frame_sequencer_if #(
  parameter int NCH = 8,
  parameter int DW  = 24
);
  logic                frame_strobe;
  logic [NCH*DW-1:0]   frame_data;
  logic [NCH-1:0]      ch_enable;
  logic                frame_ready;
  logic [DW-1:0]       adc_data_out;
  logic [2:0]          adc_channel_sel;
  logic                adc_data_ready;

  modport master (
    output frame_strobe, frame_data, ch_enable,
    input  frame_ready, adc_data_out, adc_channel_sel, adc_data_ready
  );

  modport slave (
    input  frame_strobe, frame_data, ch_enable,
    output frame_ready, adc_data_out, adc_channel_sel, adc_data_ready
  );
endinterface
`default_nettype wire

// File: rtl/adc_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : adc_frame_sequencer
//  Description : Serialises one latched 8-channel ADC frame into single-cycle
//                sample pulses with a fixed idle gap, skipping masked
//                channels. Counts completed and dropped frames; an active-low
//                emergency halt aborts the frame in flight.
//                Optional macro BOREAL_SEQ_PKT_TRIG_EN adds send_packet_strobe,
//                pulsed on every PKT_DIV-th completed frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_frame_sequencer #(
  parameter int NCH = 8,
  parameter int DW  = 24,
  parameter int GAP = 2
`ifdef BOREAL_SEQ_PKT_TRIG_EN
  , parameter int PKT_DIV = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  emergency_halt_n,
  adc_frame_sequencer_if.slave  bus,
  output logic                  busy,
  output logic                  halted,
  output logic [15:0]           frame_count,
  output logic [7:0]            overrun_count
`ifdef BOREAL_SEQ_PKT_TRIG_EN
  , output logic                send_packet_strobe
`endif
);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_load = 3'd1;
  localparam logic [2:0] c_st_emit = 3'd2;
  localparam logic [2:0] c_st_gap  = 3'd3;
  localparam logic [2:0] c_st_halt = 3'd4;

  // Wraps to 4'hF when GAP is 0; the GAP state is unreachable in that case.
  localparam logic [3:0] c_gap_last = 4'(GAP - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [NCH*DW-1:0] r_frame;
  logic [NCH-1:0]    r_mask;
  logic [3:0]        r_gap_cnt;
  logic [DW-1:0]     r_data_out;
  logic [2:0]        r_sel;
  logic              r_ready;

  logic              w_frame_ready;
  logic              w_accept;
  logic              w_overrun;
  logic              w_launch;   // a sample pulse is registered this edge
  logic              w_done;     // frame completes this edge
  logic              w_any;
  logic [2:0]        w_next_ch;
  logic [NCH-1:0]    w_onehot;
  logic [DW-1:0]     w_sample;

  assign w_frame_ready = (r_state == c_st_idle) && emergency_halt_n;
  assign w_accept      = bus.frame_strobe && w_frame_ready;
  assign w_overrun     = bus.frame_strobe &&
                         ((r_state == c_st_load) || (r_state == c_st_emit) ||
                          (r_state == c_st_gap));
  assign w_any         = |r_mask;

  assign bus.frame_ready     = w_frame_ready;
  assign bus.adc_data_out    = r_data_out;
  assign bus.adc_channel_sel = r_sel;
  assign bus.adc_data_ready  = r_ready;

  // Lowest-index channel still pending in the latched mask, with its sample
  always_comb begin
    w_next_ch = 3'd0;
    w_onehot  = '0;
    w_sample  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (r_mask[i]) begin
        w_next_ch   = 3'(i);
        w_onehot    = '0;
        w_onehot[i] = 1'b1;
        w_sample    = r_frame[i*DW +: DW];
      end
    end
  end

  // Next-state decode; halt overrides every state
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_done      = 1'b0;
    if (!emergency_halt_n) begin
      w_state_nxt = c_st_halt;
    end else begin
      case (r_state)
        c_st_idle: if (bus.frame_strobe) w_state_nxt = c_st_load;
        c_st_load: begin
          if (w_any) begin
            w_state_nxt = c_st_emit;
            w_launch    = 1'b1;
          end else begin
            w_state_nxt = c_st_idle;
          end
        end
        c_st_emit: begin
          if (GAP != 0) begin
            w_state_nxt = c_st_gap;
          end else if (w_any) begin
            w_launch = 1'b1;
          end else begin
            w_state_nxt = c_st_idle;
            w_done      = 1'b1;
          end
        end
        c_st_gap: begin
          if (r_gap_cnt == c_gap_last) begin
            if (w_any) begin
              w_state_nxt = c_st_emit;
              w_launch    = 1'b1;
            end else begin
              w_state_nxt = c_st_idle;
              w_done      = 1'b1;
            end
          end
        end
        c_st_halt: w_state_nxt = c_st_idle;
        default:   w_state_nxt = c_st_idle;
      endcase
    end
  end

  // State register with busy/halted flags registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      busy    <= 1'b0;
      halted  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt != c_st_idle);
      halted  <= (w_state_nxt == c_st_halt);
    end
  end

  // Frame/mask snapshot on accept; retire each channel as its pulse launches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= '0;
      r_mask  <= '0;
    end else if (w_accept) begin
      r_frame <= bus.frame_data;
      r_mask  <= bus.ch_enable;
    end else if (w_launch) begin
      r_mask  <= r_mask & ~w_onehot;
    end
  end

  // Sample outputs: one-cycle valid pulse, data/channel hold between pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready    <= 1'b0;
      r_sel      <= 3'd0;
      r_data_out <= '0;
    end else begin
      r_ready <= w_launch;
      if (w_launch) begin
        r_sel      <= w_next_ch;
        r_data_out <= w_sample;
      end
    end
  end

  // Idle-gap counter, restarted on every emitted sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap_cnt <= 4'd0;
    end else if (r_state == c_st_emit) begin
      r_gap_cnt <= 4'd0;
    end else if (r_state == c_st_gap) begin
      r_gap_cnt <= r_gap_cnt + 4'd1;
    end
  end

  // Completed-frame counter (wrapping) and dropped-strobe counter (saturating)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count   <= 16'd0;
      overrun_count <= 8'd0;
    end else begin
      if (w_done) frame_count <= frame_count + 16'd1;
      if (w_overrun && (overrun_count != 8'hFF)) overrun_count <= overrun_count + 8'd1;
    end
  end

`ifdef BOREAL_SEQ_PKT_TRIG_EN
  logic [15:0] r_div;

  // Packet trigger divider, advanced only by completed frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div              <= 16'd0;
      send_packet_strobe <= 1'b0;
    end else begin
      send_packet_strobe <= 1'b0;
      if (w_done) begin
        if (r_div == 16'(PKT_DIV - 1)) begin
          r_div              <= 16'd0;
          send_packet_strobe <= 1'b1;
        end else begin
          r_div <= r_div + 16'd1;
        end
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/adc_frame_sequencer.md
Name: adc_frame_sequencer

Overview:
Serialises one parallel 8-channel ADC frame from the analog front-end into the per-sample interface consumed by boreal_cursor_top (adc_data_out, adc_channel_sel, adc_data_ready pulses).
- Enforces a fixed inter-sample gap and skips masked channels.
- Counts completed and dropped frames.
- Aborts on emergency halt.
- Sits between the front-end frame capture and the cursor core.

Parameters:
NCH, 8, number of channels (1..8).
DW, 24, sample width in bits.
GAP, 2, idle cycles after each adc_data_ready pulse (0..15).
PKT_DIV, 16, frames per packet trigger (optional feature only, 1..65535).

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
emergency_halt_n  in  1  active-low halt, synchronous level input.
frame_strobe  in  1  one-cycle pulse: frame_data valid this cycle; no backpressure.
frame_data  in  NCH*DW  packed samples; channel i occupies bits [i*DW +: DW].
ch_enable  in  NCH  channel mask, sampled with the frame.
frame_ready  out  1  sequencer will accept a strobe this cycle.
adc_data_out  out  DW  current sample.
adc_channel_sel  out  3  current channel index.
adc_data_ready  out  1  one-cycle sample-valid pulse.
busy  out  1  state is not IDLE.
halted  out  1  state is HALT.
frame_count  out  16  completed frames; wraps at 65535 to 0.
overrun_count  out  8  dropped strobes; saturates at 255.

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset: state IDLE. All outputs 0, except frame_ready = emergency_halt_n. Latched frame and mask cleared.
- Output timing:
  - All outputs except frame_ready are registered.
  - frame_ready = (state==IDLE) && emergency_halt_n, combinational.
- State machine:
  - IDLE:
    - Strobe with frame_ready: latch frame_data and ch_enable, go to LOAD.
    - Strobe with halt low is dropped and not counted.
  - LOAD:
    - Find the lowest-index enabled channel.
    - Mask all zero: return to IDLE; no pulses; frame_count unchanged.
    - Otherwise go to EMIT.
  - EMIT:
    - Registered outputs drive adc_data_ready=1, adc_channel_sel=ch, adc_data_out=sample[ch] for exactly one cycle.
    - Clear that channel's bit in the latched mask.
    - Go to GAP.
  - GAP:
    - Count GAP cycles with adc_data_ready=0.
    - adc_data_out and adc_channel_sel hold their last values.
    - Then go to EMIT on the next enabled channel, or to IDLE if none remain.
    - frame_count increments on the transition to IDLE.
    - GAP=0 means EMIT-to-EMIT back-to-back.
  - HALT: see Halt below.
- Latency, strobe accepted at cycle t:
  - Pulse k (k=0..n-1, n = number of enabled channels) is high at t+2+k*(GAP+1).
  - Sequencer is back in IDLE (frame_count updated, frame_ready high) at t+2+n*(GAP+1).
  - NCH=8, GAP=2, full mask: pulses at t+2..t+23 step 3; IDLE at t+26.
- Overrun:
  - frame_strobe while state!=IDLE and not HALT: strobe dropped, overrun_count+1 (saturating).
  - A strobe in the exact cycle the FSM re-enters IDLE is accepted.
- Halt:
  - emergency_halt_n low in any state: next state HALT.
  - No adc_data_ready pulse in the following cycle; a pulse already registered in the same cycle still completes.
  - The in-flight frame is discarded and not counted.
  - HALT: halted=1, busy=1, strobes ignored and not counted.
  - Exit to IDLE the cycle after emergency_halt_n is sampled high.
- Reset mid-frame: immediate return to reset values; counters cleared.
- Mask change: ch_enable changes during a frame have no effect; the mask is snapshotted at accept.

Optional Feature:
Macro BOREAL_SEQ_PKT_TRIG_EN.
- Defined:
  - Extra output send_packet_strobe (1 bit) and internal 16-bit frame divider counter.
  - On every PKT_DIV-th completed frame, send_packet_strobe is high for one cycle, coincident with the frame_count increment.
  - Divider clears on reset. Divider is unchanged by halt or aborted frames.
- Not defined:
  - Port and counter absent.
  - Packet strobes come from upstream as today.

Test Plan:
1. Reset 200 ns, then release -> all outputs 0, frame_ready=1, busy=0, frame_count=0, overrun_count=0.
2. Full frame: mask 8'hFF, ch i = 24'h010000*(i+1), strobe at t -> 8 pulses at t+2,t+5,...,t+23. sel 0..7 in order, data 24'h010000..24'h080000. frame_count=1 and frame_ready=1 at t+26.
3. Sparse mask: mask 8'h05 -> pulses only at t+2 (sel 0) and t+5 (sel 2); IDLE at t+8. Mask 8'h00 -> no pulses, frame_count unchanged, IDLE at t+2.
4. Overrun: strobe at t, second strobe at t+10, third at t+26 -> overrun_count=1. 16 pulses total; frame_count=2 at t+52.
5. Halt: emergency_halt_n low at t+7 for 5 cycles -> pulse at t+5 seen, none from t+8 onward. halted=1 at t+8, frame_count unchanged, strobes during halt leave overrun_count=0. IDLE one cycle after release.
6. BOREAL_SEQ_PKT_TRIG_EN with PKT_DIV=4: 8 full frames -> exactly two send_packet_strobe pulses, coincident with frame_count 3->4 and 7->8.
